// File: rtl/tx_stream_arbiter_pkg.sv
// Shared types and constants for the transmit stream arbiter.
// State encodings match the legacy defines (IDLE=0, HEADER=1, STREAM=2).
package tx_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHeader = 2'd1,
        StStream = 2'd2
    } arb_state_e;

    localparam logic [7:0] TX_HEADER_TAG = 8'hA0;

    // Stall counter width; a disabled watchdog still needs a legal vector width.
    function automatic int unsigned stall_cnt_width(input int unsigned cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first set request after index `last`, wrapping modulo N_REQ.
module rr_priority_select #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last) + k) % N_REQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// N-source frame arbiter towards the FT245 transmit interface: round-robin grant per frame,
// enable mask, optional source-tagged header word and a stall watchdog.
module tx_stream_arbiter
    import tx_stream_arbiter_pkg::*;
#(
    parameter int unsigned          N_SOURCES      = 4,
    parameter int unsigned          TX_WIDTH       = 8,
    parameter bit                   HEADER_EN      = 1'b1,
    parameter logic [TX_WIDTH-1:0]  HEADER_TAG     = TX_WIDTH'(TX_HEADER_TAG),
    parameter int unsigned          TIMEOUT_CYCLES = 1024,
    localparam int unsigned         ID_WIDTH       = $clog2(N_SOURCES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SOURCES*TX_WIDTH-1:0] src_data,
    input  logic [N_SOURCES-1:0]          src_rdy,
    input  logic [N_SOURCES-1:0]          src_eof,
    output logic [N_SOURCES-1:0]          src_ack,
    input  logic [N_SOURCES-1:0]          src_en,
    output logic [TX_WIDTH-1:0]           tx_data,
    output logic                          tx_rdy,
    input  logic                          tx_ack,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           cur_src,
    output logic                          timeout_o
);

    arb_state_e           state_q, state_d;
    logic [ID_WIDTH-1:0]  cur_q, cur_d;
    logic [ID_WIDTH-1:0]  last_q, last_d;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic                 grant_valid;
    logic [TX_WIDTH-1:0]  cur_word;
    logic                 cur_rdy;
    logic                 cur_eof;
    logic                 stall_expired;

    rr_priority_select #(
        .N_REQ (N_SOURCES),
        .IDX_W (ID_WIDTH)
    ) u_rr_select (
        .req         (src_rdy & src_en),
        .last        (last_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign cur_word = src_data[cur_q*TX_WIDTH +: TX_WIDTH];
    assign cur_rdy  = src_rdy[cur_q];
    assign cur_eof  = src_eof[cur_q];

    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int unsigned CntW = stall_cnt_width(TIMEOUT_CYCLES);

        logic [CntW-1:0] stall_q, stall_d;

        always_comb begin
            stall_d = '0;
            if (state_q == StStream && !cur_rdy) begin
                stall_d = stall_q + CntW'(1);
            end
        end

        // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
        assign stall_expired = (state_q == StStream) && !cur_rdy &&
                               (stall_q == CntW'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_d;
            end
        end
    end else begin : g_no_wdog
        assign stall_expired = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        tx_data   = '0;
        tx_rdy    = 1'b0;
        src_ack   = '0;
        timeout_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    cur_d   = grant_idx;
                    state_d = HEADER_EN ? StHeader : StStream;
                end
            end
            StHeader: begin
                tx_rdy  = 1'b1;
                tx_data = {HEADER_TAG[TX_WIDTH-1:ID_WIDTH], cur_q};
                if (tx_ack) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                tx_rdy  = cur_rdy;
                tx_data = cur_word;
                if (tx_ack && cur_rdy) begin
                    src_ack[cur_q] = 1'b1;
                    if (cur_eof) begin
                        last_d  = cur_q;
                        state_d = StIdle;
                    end
                end else if (stall_expired) begin
                    timeout_o = 1'b1;
                    last_d    = cur_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cur_q   <= '0;
            last_q  <= ID_WIDTH'(N_SOURCES - 1);
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign cur_src = cur_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter: queued source models, expected-word queue and a
// negedge monitor that pops and compares every transfer.
module tb_tx_stream_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       eof;
    } word_t;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_data;
    logic [3:0]  src_rdy;
    logic [3:0]  src_eof;
    logic [3:0]  src_ack;
    logic [3:0]  src_en;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        tx_ack;
    logic        busy;
    logic [1:0]  cur_src;
    logic        timeout_o;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    ack_cnt[4];
    word_t srcq[4][$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    logic [3:0] acks_seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_stream_arbiter #(
        .N_SOURCES      (4),
        .TX_WIDTH       (8),
        .HEADER_EN      (1'b1),
        .HEADER_TAG     (8'hA0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_rdy   (src_rdy),
        .src_eof   (src_eof),
        .src_ack   (src_ack),
        .src_en    (src_en),
        .tx_data   (tx_data),
        .tx_rdy    (tx_rdy),
        .tx_ack    (tx_ack),
        .busy      (busy),
        .cur_src   (cur_src),
        .timeout_o (timeout_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic eof);
        word_t w;
        w.d   = d;
        w.eof = eof;
        srcq[s].push_back(w);
    endtask

    task automatic expect_word(input logic [7:0] d, input logic [3:0] ack);
        exp_t e;
        e.d   = d;
        e.ack = ack;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        tx_ack = 1'b0;
        src_en = 4'b1111;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Waits for the header word to transfer, then withholds tx_ack from the next edge on.
    task automatic stall_after_header(input string name, input logic [7:0] hdr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_rdy && tx_ack && tx_data == hdr) begin
                found = 1'b1;
                break;
            end
        end
        check(name, found, 1);
        @(posedge clk);
        #1;
        tx_ack = 1'b0;
    endtask

    // Source models: hold the front word until acked, as the simple interface requires.
    initial begin
        src_rdy  = '0;
        src_eof  = '0;
        src_data = '0;
        forever begin
            @(negedge clk);
            acks_seen = src_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acks_seen[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    src_rdy[i]          = 1'b1;
                    src_eof[i]          = srcq[i][0].eof;
                    src_data[i*8 +: 8]  = srcq[i][0].d;
                end else begin
                    src_rdy[i]          = 1'b0;
                    src_eof[i]          = 1'b0;
                    src_data[i*8 +: 8]  = 8'h00;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) if (src_ack[i]) ack_cnt[i]++;
            if (tx_rdy && tx_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no transfer", tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_data", tx_data, mon_e.d);
                    check("src_ack", src_ack, mon_e.ack);
                end
            end else if (tx_ack) begin
                check("ack_without_rdy", src_ack, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int base[4];
        int t_word;
        logic found;

        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        rst    = 1'b0;
        tx_ack = 1'b0;
        src_en = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_rdy", tx_rdy, 0);
        check("rst_src_ack", src_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_src", cur_src, 0);
        check("rst_timeout", timeout_o, 0);

        // Three-word frame from source 2 with header.
        do_reset();
        tx_ack = 1'b1;
        base[2] = ack_cnt[2];
        expect_word(8'hA2, 4'b0000);
        expect_word(8'h11, 4'b0100);
        expect_word(8'h22, 4'b0100);
        expect_word(8'h33, 4'b0100);
        send(2, 8'h11, 1'b0);
        send(2, 8'h22, 1'b0);
        send(2, 8'h33, 1'b1);
        wait_drain("t1_drain", 40);
        check("t1_busy_on_eof", busy, 1);
        @(negedge clk);
        #1;
        check("t1_busy_fall", busy, 0);
        check("t1_ack_pulses", ack_cnt[2] - base[2], 3);

        // Round robin across sources 0, 1, 3 with two 1-word frames each.
        do_reset();
        tx_ack = 1'b1;
        for (int i = 0; i < 4; i++) base[i] = ack_cnt[i];
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 4; s++) begin
                if (s != 2) begin
                    send(s, 8'(s * 16 + r), 1'b1);
                    expect_word(8'hA0 | 8'(s), 4'b0000);
                    expect_word(8'(s * 16 + r), 4'(1 << s));
                end
            end
        end
        wait_drain("t2_drain", 80);
        check("t2_acks_src0", ack_cnt[0] - base[0], 2);
        check("t2_acks_src1", ack_cnt[1] - base[1], 2);
        check("t2_acks_src2", ack_cnt[2] - base[2], 0);
        check("t2_acks_src3", ack_cnt[3] - base[3], 2);

        // Masked source is ignored until enabled.
        do_reset();
        tx_ack = 1'b1;
        src_en = 4'b1101;
        send(1, 8'h5A, 1'b1);
        expect_word(8'hA1, 4'b0000);
        expect_word(8'h5A, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("t3_masked_rdy", tx_rdy, 0);
        end
        check("t3_masked_busy", busy, 0);
        @(posedge clk);
        #1;
        src_en = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t3_grant_latency", tx_rdy, 1);
        wait_drain("t3_drain", 20);

        // Watchdog: source 0 stalls after one word without eof.
        do_reset();
        tx_ack = 1'b1;
        send(0, 8'h40, 1'b0);
        send(1, 8'h41, 1'b1);
        expect_word(8'hA0, 4'b0000);
        expect_word(8'h40, 4'b0001);
        expect_word(8'hA1, 4'b0000);
        expect_word(8'h41, 4'b0010);
        found  = 1'b0;
        t_word = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_rdy && tx_ack && tx_data == 8'h40) begin
                found  = 1'b1;
                t_word = cyc;
                break;
            end
        end
        check("t4_word_seen", found, 1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (timeout_o) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_timeout_seen", found, 1);
        check("t4_timeout_delay", cyc - t_word, 8);
        @(negedge clk);
        check("t4_timeout_single", timeout_o, 0);
        wait_drain("t4_drain", 20);

        // Reset mid-frame while source 1 presents 0x55.
        do_reset();
        tx_ack = 1'b1;
        base[1] = ack_cnt[1];
        send(1, 8'h55, 1'b1);
        expect_word(8'hA1, 4'b0000);
        stall_after_header("t5_header_seen", 8'hA1);
        @(negedge clk);
        #1;
        check("t5_presenting", tx_data, 8'h55);
        rst    = 1'b0;
        tx_ack = 1'b1;
        #1;
        check("t5_rst_tx_data", tx_data, 0);
        check("t5_rst_tx_rdy", tx_rdy, 0);
        check("t5_rst_src_ack", src_ack, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_cur_src", cur_src, 0);
        check("t5_rst_timeout", timeout_o, 0);
        check("t5_no_ack_pulse", ack_cnt[1] - base[1], 0);
        expect_word(8'hA1, 4'b0000);
        expect_word(8'h55, 4'b0010);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_drain("t5_drain", 20);
        check("t5_resent_once", ack_cnt[1] - base[1], 1);

        // Sink back-pressure longer than the watchdog limit with src_rdy held high.
        do_reset();
        tx_ack = 1'b1;
        send(2, 8'h77, 1'b1);
        expect_word(8'hA2, 4'b0000);
        expect_word(8'h77, 4'b0100);
        stall_after_header("t6_header_seen", 8'hA2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("t6_stable_data", tx_data, 8'h77);
            check("t6_stable_rdy", tx_rdy, 1);
            check("t6_no_timeout", timeout_o, 0);
        end
        @(posedge clk);
        #1;
        tx_ack = 1'b1;
        wait_drain("t6_drain", 20);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
